// File: rtl/fine_scroll_delay_ctrl.sv
// Fine-scroll control master for the 6-bit pixel delay line.
// Holds a CPU-programmed fine-scroll value and commits it only on blank
// edges, so the delay tap never moves mid-line.
// Optional feature macro: RASTER_SPLIT_EN. When it is defined, a per-line
// split table with override logic is mapped at addr 4..11.
module fine_scroll_delay_ctrl #(
    parameter int SPLITS = 4,
    parameter int LINE_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_i,
    input  logic [3:0]        addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o,
    input  logic              hblank_i,
    input  logic              vblank_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [1:0]        sel_o,
    output logic              delay_o,
    output logic              pending_o
);

    // Fine values above 4 are not representable on the delay line.
    function automatic logic [2:0] clamp_v(input logic [2:0] w);
        return (w > 3'd4) ? 3'd4 : w;
    endfunction

    // Map v to {delay, sel}: 0..3 pick a tap, 4 adds the extra stage.
    function automatic logic [2:0] encode_v(input logic [2:0] v);
        return (v == 3'd4) ? 3'b1_11 : {1'b0, v[1:0]};
    endfunction

    logic       hblank_q, vblank_q;
    logic [2:0] pend_val_q, pend_val_d;
    logic       mode_q, mode_d;
    logic       pending_q, pending_d;
    logic [2:0] base_q, base_d;
    logic [1:0] sel_q, sel_d;
    logic       delay_q, delay_d;
    logic [2:0] applied_q, applied_d;
    logic       ov_active;

    wire hb_rise = hblank_i & ~hblank_q;
    wire vb_rise = vblank_i & ~vblank_q;

`ifdef RASTER_SPLIT_EN
    logic [LINE_W-1:0] spl_line_q [SPLITS];
    logic [LINE_W-1:0] spl_line_d [SPLITS];
    logic [2:0]        spl_val_q  [SPLITS];
    logic [2:0]        spl_val_d  [SPLITS];
    logic              spl_en_q   [SPLITS];
    logic              spl_en_d   [SPLITS];
    logic              ov_q, ov_d;
    logic [2:0]        ov_val_q, ov_val_d;
    logic              unused_wbits;

    assign unused_wbits = ^wdata_i[6:4];
    assign ov_active    = ov_q;
`else
    logic unused_inputs;

    assign unused_inputs = ^{wdata_i[7:4], line_i};
    assign ov_active     = 1'b0;
`endif

    // Edge processing (vblank before hblank), then the CPU write lands on top.
    always_comb begin
        pend_val_d = pend_val_q;
        mode_d     = mode_q;
        pending_d  = pending_q;
        base_d     = base_q;
        sel_d      = sel_q;
        delay_d    = delay_q;
        applied_d  = applied_q;
`ifdef RASTER_SPLIT_EN
        spl_line_d = spl_line_q;
        spl_val_d  = spl_val_q;
        spl_en_d   = spl_en_q;
        ov_d       = ov_q;
        ov_val_d   = ov_val_q;
`endif
        if (vb_rise) begin
`ifdef RASTER_SPLIT_EN
            ov_d = 1'b0;
`endif
            if (pending_q && mode_q) begin
                base_d    = pend_val_q;
                pending_d = 1'b0;
            end
        end
        if (hb_rise) begin
            if (pending_q && !mode_q) begin
                base_d    = pend_val_q;
                pending_d = 1'b0;
            end
`ifdef RASTER_SPLIT_EN
            // Descending scan so the lowest matching index is the one kept.
            if (!vblank_i) begin
                for (int k = SPLITS - 1; k >= 0; k--) begin
                    if (spl_en_q[k] && (spl_line_q[k] == line_i)) begin
                        ov_d     = 1'b1;
                        ov_val_d = spl_val_q[k];
                    end
                end
            end
`endif
        end
        if (hb_rise || vb_rise) begin
`ifdef RASTER_SPLIT_EN
            applied_d = ov_d ? ov_val_d : base_d;
`else
            applied_d = base_d;
`endif
            {delay_d, sel_d} = encode_v(applied_d);
        end
        if (wr_i) begin
            if (addr_i == 4'd0) begin
                pend_val_d = clamp_v(wdata_i[2:0]);
                mode_d     = wdata_i[3];
                pending_d  = 1'b1;
            end
`ifdef RASTER_SPLIT_EN
            for (int k = 0; k < SPLITS; k++) begin
                if (addr_i == 4'(4 + k)) begin
                    spl_line_d[k] = LINE_W'(wdata_i);
                end
                if (addr_i == 4'(8 + k)) begin
                    spl_val_d[k] = clamp_v(wdata_i[2:0]);
                    spl_en_d[k]  = wdata_i[7];
                end
            end
`endif
        end
    end

    // State registers; reset discards any uncommitted write and the split table.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hblank_q   <= 1'b0;
            vblank_q   <= 1'b0;
            pend_val_q <= 3'd0;
            mode_q     <= 1'b0;
            pending_q  <= 1'b0;
            base_q     <= 3'd0;
            sel_q      <= 2'd0;
            delay_q    <= 1'b0;
            applied_q  <= 3'd0;
`ifdef RASTER_SPLIT_EN
            ov_q       <= 1'b0;
            ov_val_q   <= 3'd0;
            for (int k = 0; k < SPLITS; k++) begin
                spl_line_q[k] <= '0;
                spl_val_q[k]  <= 3'd0;
                spl_en_q[k]   <= 1'b0;
            end
`endif
        end else begin
            hblank_q   <= hblank_i;
            vblank_q   <= vblank_i;
            pend_val_q <= pend_val_d;
            mode_q     <= mode_d;
            pending_q  <= pending_d;
            base_q     <= base_d;
            sel_q      <= sel_d;
            delay_q    <= delay_d;
            applied_q  <= applied_d;
`ifdef RASTER_SPLIT_EN
            ov_q       <= ov_d;
            ov_val_q   <= ov_val_d;
            spl_line_q <= spl_line_d;
            spl_val_q  <= spl_val_d;
            spl_en_q   <= spl_en_d;
`endif
        end
    end

    // Combinational register readback.
    always_comb begin
        rdata_o = 8'h00;
        if (addr_i == 4'd0) begin
            rdata_o = {4'b0, mode_q, pend_val_q};
        end else if (addr_i == 4'd1) begin
            rdata_o = {pending_q, ov_active, 3'b0, applied_q};
        end
`ifdef RASTER_SPLIT_EN
        for (int k = 0; k < SPLITS; k++) begin
            if (addr_i == 4'(4 + k)) begin
                rdata_o = 8'(spl_line_q[k]);
            end
            if (addr_i == 4'(8 + k)) begin
                rdata_o = {spl_en_q[k], 4'b0, spl_val_q[k]};
            end
        end
`endif
    end

    assign sel_o     = sel_q;
    assign delay_o   = delay_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_fine_scroll_delay_ctrl.sv
// Directed testbench for fine_scroll_delay_ctrl: a vector table for the
// commit/encode behaviour plus hand sequences for reset and split overrides.
module tb_fine_scroll_delay_ctrl;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       wr_i = 1'b0;
    logic [3:0] addr_i = 4'd1;
    logic [7:0] wdata_i = 8'h00;
    logic [7:0] rdata_o;
    logic       hblank_i = 1'b0;
    logic       vblank_i = 1'b0;
    logic [7:0] line_i = 8'h00;
    logic [1:0] sel_o;
    logic       delay_o;
    logic       pending_o;

    int errors = 0;
    int checks = 0;

`ifdef RASTER_SPLIT_EN
    localparam bit SPL = 1'b1;
`else
    localparam bit SPL = 1'b0;
`endif

    fine_scroll_delay_ctrl #(.SPLITS(4), .LINE_W(8)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_i      (wr_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .hblank_i  (hblank_i),
        .vblank_i  (vblank_i),
        .line_i    (line_i),
        .sel_o     (sel_o),
        .delay_o   (delay_o),
        .pending_o (pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       hb;
        logic       vb;
        logic [1:0] sel;
        logic       dly;
        logic       pend;
        logic [7:0] rd;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic w, input logic [3:0] a, input logic [7:0] d,
                                input logic hb, input logic vb, input logic [1:0] s,
                                input logic dl, input logic p, input logic [7:0] r);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.hb = hb; v.vb = vb;
        v.sel = s; v.dly = dl; v.pend = p; v.rd = r;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [1:0] s, input logic dl,
                           input logic p, input logic [7:0] r);
        chk({name, ".sel"},     {6'b0, sel_o},     {6'b0, s});
        chk({name, ".delay"},   {7'b0, delay_o},   {7'b0, dl});
        chk({name, ".pending"}, {7'b0, pending_o}, {7'b0, p});
        chk({name, ".rdata"},   rdata_o,           r);
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic w, input logic [3:0] a, input logic [7:0] d,
                        input logic hb, input logic vb, input logic [7:0] ln);
        wr_i = w; addr_i = a; wdata_i = d; hblank_i = hb; vblank_i = vb; line_i = ln;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        //                wr addr  wdata  hb vb  sel d  p  rdata
        tbl[0]  = mk(0, 4'd1, 8'h00, 0, 0, 2'd0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 4'd0, 8'h03, 0, 0, 2'd0, 0, 1, 8'h03);
        tbl[2]  = mk(0, 4'd1, 8'h00, 0, 0, 2'd0, 0, 1, 8'h80);
        tbl[3]  = mk(0, 4'd1, 8'h00, 1, 0, 2'd3, 0, 0, 8'h03);
        tbl[4]  = mk(0, 4'd1, 8'h00, 1, 0, 2'd3, 0, 0, 8'h03);
        tbl[5]  = mk(0, 4'd1, 8'h00, 0, 0, 2'd3, 0, 0, 8'h03);
        tbl[6]  = mk(1, 4'd0, 8'h0F, 0, 0, 2'd3, 0, 1, 8'h0C);
        tbl[7]  = mk(0, 4'd1, 8'h00, 1, 0, 2'd3, 0, 1, 8'h83);
        tbl[8]  = mk(0, 4'd1, 8'h00, 0, 0, 2'd3, 0, 1, 8'h83);
        tbl[9]  = mk(0, 4'd1, 8'h00, 1, 0, 2'd3, 0, 1, 8'h83);
        tbl[10] = mk(0, 4'd1, 8'h00, 0, 0, 2'd3, 0, 1, 8'h83);
        tbl[11] = mk(0, 4'd1, 8'h00, 1, 0, 2'd3, 0, 1, 8'h83);
        tbl[12] = mk(0, 4'd1, 8'h00, 0, 0, 2'd3, 0, 1, 8'h83);
        tbl[13] = mk(0, 4'd1, 8'h00, 0, 1, 2'd3, 1, 0, 8'h04);
        tbl[14] = mk(0, 4'd1, 8'h00, 0, 0, 2'd3, 1, 0, 8'h04);
        tbl[15] = mk(1, 4'd0, 8'h02, 1, 0, 2'd3, 1, 1, 8'h02);
        tbl[16] = mk(0, 4'd1, 8'h00, 0, 0, 2'd3, 1, 1, 8'h84);
        tbl[17] = mk(0, 4'd1, 8'h00, 1, 0, 2'd2, 0, 0, 8'h02);
        tbl[18] = mk(0, 4'd1, 8'h00, 0, 0, 2'd2, 0, 0, 8'h02);
        tbl[19] = mk(1, 4'd0, 8'h09, 0, 0, 2'd2, 0, 1, 8'h09);
        tbl[20] = mk(0, 4'd1, 8'h00, 1, 1, 2'd1, 0, 0, 8'h01);
        tbl[21] = mk(0, 4'd1, 8'h00, 0, 0, 2'd1, 0, 0, 8'h01);
        tbl[22] = mk(1, 4'd0, 8'h05, 0, 0, 2'd1, 0, 1, 8'h04);
        tbl[23] = mk(0, 4'd1, 8'h00, 0, 1, 2'd1, 0, 1, 8'h81);
        tbl[24] = mk(0, 4'd1, 8'h00, 0, 0, 2'd1, 0, 1, 8'h81);
        tbl[25] = mk(0, 4'd1, 8'h00, 1, 0, 2'd3, 1, 0, 8'h04);
        tbl[26] = mk(0, 4'd1, 8'h00, 0, 0, 2'd3, 1, 0, 8'h04);
        tbl[27] = mk(1, 4'd2, 8'hFF, 0, 0, 2'd3, 1, 0, 8'h00);
        tbl[28] = mk(1, 4'hF, 8'hFF, 0, 0, 2'd3, 1, 0, 8'h00);

        // Reset held: outputs cleared.
        step(0, 4'd1, 8'h00, 0, 0, 8'h00);
        step(0, 4'd1, 8'h00, 0, 0, 8'h00);
        chk_out("reset", 2'd0, 1'b0, 1'b0, 8'h00);
        reset_i = 1'b0;
        for (int i = 0; i < 100; i++) step(0, 4'd1, 8'h00, 0, 0, 8'h00);
        chk_out("idle100", 2'd0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].hb, tbl[i].vb, 8'h00);
            chk_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].dly, tbl[i].pend, tbl[i].rd);
        end

        // Reset mid-frame discards an uncommitted write.
        step(1, 4'd0, 8'h01, 0, 0, 8'h00);
        chk_out("pre_rst", 2'd3, 1'b1, 1'b1, 8'h01);
        reset_i = 1'b1;
        step(0, 4'd0, 8'h00, 1, 0, 8'h00);
        reset_i = 1'b0;
        chk_out("mid_rst", 2'd0, 1'b0, 1'b0, 8'h00);
        step(0, 4'd1, 8'h00, 0, 0, 8'h00);
        step(0, 4'd1, 8'h00, 1, 0, 8'h00);
        chk_out("post_rst_hb", 2'd0, 1'b0, 1'b0, 8'h00);
        step(0, 4'd1, 8'h00, 0, 0, 8'h00);

        // Split overrides: base 1, splits 0 and 1 both on line 0x20.
        step(1, 4'd0, 8'h01, 0, 0, 8'h00);
        step(0, 4'd1, 8'h00, 1, 0, 8'h00);
        chk_out("base1", 2'd1, 1'b0, 1'b0, 8'h01);
        step(0, 4'd1, 8'h00, 0, 0, 8'h00);
        step(1, 4'd4, 8'h20, 0, 0, 8'h00);
        step(1, 4'd8, 8'h82, 0, 0, 8'h00);
        chk("split0_rd", rdata_o, SPL ? 8'h82 : 8'h00);
        step(1, 4'd5, 8'h20, 0, 0, 8'h00);
        chk("split1_line_rd", rdata_o, SPL ? 8'h20 : 8'h00);
        step(1, 4'd9, 8'h84, 0, 0, 8'h00);
        step(0, 4'd1, 8'h00, 1, 0, 8'h20);
        chk_out("split_hit", SPL ? 2'd2 : 2'd1, 1'b0, 1'b0, SPL ? 8'h42 : 8'h01);
        step(0, 4'd1, 8'h00, 0, 0, 8'h20);
        step(0, 4'd1, 8'h00, 1, 0, 8'h21);
        chk_out("split_persist", SPL ? 2'd2 : 2'd1, 1'b0, 1'b0, SPL ? 8'h42 : 8'h01);
        step(0, 4'd1, 8'h00, 0, 0, 8'h21);
        step(0, 4'd1, 8'h00, 0, 1, 8'h21);
        chk_out("split_vb_clear", 2'd1, 1'b0, 1'b0, 8'h01);
        step(0, 4'd1, 8'h00, 0, 0, 8'h21);

        // Simultaneous edges: vblank commit wins, split match suppressed.
        step(1, 4'd0, 8'h0A, 0, 0, 8'h20);
        chk("sim_pend", {7'b0, pending_o}, 8'h01);
        step(0, 4'd1, 8'h00, 1, 1, 8'h20);
        chk_out("sim_edges", 2'd2, 1'b0, 1'b0, 8'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
